ext_mem_responder: RTL and testbench

Responder model for the DMAC secondary (external) memory port. It answers single-word read and write requests from the initiator using a run-time programmable number of wait states. It drives `stall` back to the DMAC for the length of each access and acknowledges completion. It replaces the zero-latency external memory model in DMAC benches, so the initiator's stall handling is exercised with real backpressure.

---
 rtl/ext_mem_responder.sv | 130 +++++++++++++
 tb/tb_ext_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ext_mem_responder.sv
// Wait-state external memory responder for the DMAC secondary port.
// Single-word reads/writes; each access stalls for a programmable count, then acks.
module ext_mem_responder #(
    parameter int DMA_SIZE   = 16,
    parameter int DMD_SIZE   = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_rd,
    input  logic [DMA_SIZE-1:0] addr,
    input  logic [DMD_SIZE-1:0] data_in,
    input  logic [3:0]          wait_cfg,
    output logic [DMD_SIZE-1:0] data_out,
    output logic                stall,
    output logic                ack,
    output logic                err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DMA_SIZE-1:0] addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [DMD_SIZE-1:0] wdata_q, wdata_d;
    logic [DMD_SIZE-1:0] data_out_q, data_out_d;
    logic                stall_q, stall_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic [DMD_SIZE-1:0] mem_q [DEPTH];

    logic                  commit;
    logic [DMA_SIZE-1:0]   c_addr;
    logic                  c_wr;
    logic [DMD_SIZE-1:0]   c_data;
    logic                  c_oor;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic                  mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        c_addr  = addr_q;
        c_wr    = wr_q;
        c_data  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    addr_d  = addr;
                    wr_d    = wr_rd;
                    wdata_d = data_in;
                    if (wait_cfg == 4'd0) begin
                        // Zero-wait access commits straight from the port.
                        commit = 1'b1;
                        c_addr = addr;
                        c_wr   = wr_rd;
                        c_data = data_in;
                    end else begin
                        cnt_d   = wait_cfg;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        c_oor  = (c_addr >> DEPTH_LOG2) != '0;
        c_idx  = c_addr[DEPTH_LOG2-1:0];
        mem_we = commit && c_wr && !c_oor && !rst;

        data_out_d = data_out_q;
        if (commit && !c_wr)
            data_out_d = c_oor ? '0 : mem_q[c_idx];
        stall_d = (state_d == S_WAIT);
        ack_d   = commit;
        err_d   = commit && c_oor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            data_out_q <= '0;
            stall_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            stall_q    <= stall_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    // Storage survives reset; only the write enable is gated by it.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[c_idx] <= c_data;
    end

    assign data_out = data_out_q;
    assign stall    = stall_q;
    assign ack      = ack_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: vector table, hand-written reset/ignore sequences,
// and random traffic checked against an array memory model.
module tb_ext_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_rd;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [3:0]  wait_cfg;
    logic [15:0] data_out;
    logic        stall;
    logic        ack;
    logic        err;

    ext_mem_responder #(.DMA_SIZE(16), .DMD_SIZE(16), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .addr(addr),
        .data_in(data_in), .wait_cfg(wait_cfg), .data_out(data_out),
        .stall(stall), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  n;
        logic [15:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] ref_mem [256];
    bit          known [256];
    logic [15:0] last_dout;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One complete access with cycle-by-cycle stall/ack checks.
    task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [3:0] n, input logic [15:0] exp_rd,
                          input bit exp_err, input bit scramble, input string nm);
        logic [15:0] exp_d;
        en = 1'b1; wr_rd = wr; addr = a; data_in = d; wait_cfg = n;
        @(posedge clk); #1;
        en = 1'b0; wait_cfg = 4'($urandom);
        for (int k = 0; k < int'(n); k++) begin
            chk({nm, " stall"}, 32'(stall), 32'd1);
            chk({nm, " early_ack"}, 32'(ack), 32'd0);
            if (scramble) begin
                addr = 16'h0020; data_in = 16'h5555; wr_rd = ~wr;
            end
            @(posedge clk); #1;
        end
        exp_d = wr ? last_dout : exp_rd;
        chk({nm, " stall_end"}, 32'(stall), 32'd0);
        chk({nm, " ack"}, 32'(ack), 32'd1);
        chk({nm, " err"}, 32'(err), 32'(exp_err));
        chk({nm, " data_out"}, 32'(data_out), 32'(exp_d));
        last_dout = exp_d;
        if (wr && a < 16'h0100) begin
            ref_mem[a[7:0]] = d;
            known[a[7:0]]   = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr_rd = 1'b0; addr = '0; data_in = '0; wait_cfg = '0;
        last_dout = '0;

        //                wr  addr      data      n  exp_rd    err
        tbl.push_back('{1, 16'h0001, 16'h1111, 0, 16'h0000, 0});
        tbl.push_back('{1, 16'h0002, 16'h2222, 0, 16'h0000, 0});
        tbl.push_back('{1, 16'h0003, 16'h3333, 0, 16'h0000, 0});
        tbl.push_back('{1, 16'h0005, 16'h5A5A, 1, 16'h0000, 0});
        tbl.push_back('{1, 16'h0000, 16'h0F0F, 0, 16'h0000, 0});
        tbl.push_back('{1, 16'h0020, 16'h2020, 2, 16'h0000, 0});
        tbl.push_back('{1, 16'h0030, 16'h3030, 0, 16'h0000, 0});
        tbl.push_back('{0, 16'h0005, 16'h0000, 0, 16'h5A5A, 0});
        tbl.push_back('{1, 16'h0010, 16'hBEEF, 3, 16'h0000, 0});
        tbl.push_back('{0, 16'h0010, 16'h0000, 3, 16'hBEEF, 0});
        tbl.push_back('{0, 16'h0001, 16'h0000, 0, 16'h1111, 0});
        tbl.push_back('{0, 16'h0002, 16'h0000, 0, 16'h2222, 0});
        tbl.push_back('{0, 16'h0003, 16'h0000, 0, 16'h3333, 0});
        tbl.push_back('{1, 16'h0100, 16'h1234, 2, 16'h0000, 1});
        tbl.push_back('{0, 16'h0000, 16'h0000, 0, 16'h0F0F, 0});
        tbl.push_back('{0, 16'h0100, 16'h0000, 1, 16'h0000, 1});
        tbl.push_back('{0, 16'hFF00, 16'h0000, 0, 16'h0000, 1});
        tbl.push_back('{1, 16'h0040, 16'h4444, 0, 16'h0000, 0});
        tbl.push_back('{0, 16'h0040, 16'h0000, 0, 16'h4444, 0});
        tbl.push_back('{0, 16'h0000, 16'h0000, 15, 16'h0F0F, 0});
        tbl.push_back('{1, 16'h00FF, 16'hC0DE, 0, 16'h0000, 0});
        tbl.push_back('{0, 16'h00FF, 16'h0000, 2, 16'hC0DE, 0});

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_outputs", {13'd0, stall, ack, err, data_out}, 32'd0);
        end
        rst = 1'b0;

        foreach (tbl[i])
            access(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].n, tbl[i].exp_rd,
                   tbl[i].exp_err, 1'b0, $sformatf("vec%0d", i));
        @(posedge clk); #1;
        chk("idle_no_ack", 32'(ack), 32'd0);

        // Port changes during WAIT must not leak into the latched request.
        access(1'b1, 16'h0011, 16'hAAAA, 4'd4, 16'h0000, 1'b0, 1'b1, "ign_wr");
        access(1'b0, 16'h0011, 16'h0000, 4'd0, 16'hAAAA, 1'b0, 1'b0, "ign_rd11");
        access(1'b0, 16'h0020, 16'h0000, 4'd0, 16'h2020, 1'b0, 1'b0, "ign_rd20");

        // Reset two cycles into a five-cycle write.
        en = 1'b1; wr_rd = 1'b1; addr = 16'h0030; data_in = 16'h7777; wait_cfg = 4'd5;
        @(posedge clk); #1;
        en = 1'b0;
        chk("mid_rst stall_pre", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst outputs", {13'd0, stall, ack, err, data_out}, 32'd0);
        last_dout = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("mid_rst quiet", {30'd0, stall, ack}, 32'd0);
        end
        access(1'b0, 16'h0030, 16'h0000, 4'd1, 16'h3030, 1'b0, 1'b0, "mid_rst rd30");

        // Reset wins over a same-edge zero-wait write.
        rst = 1'b1; en = 1'b1; wr_rd = 1'b1; addr = 16'h0005; data_in = 16'hDEAD; wait_cfg = 4'd0;
        @(posedge clk); #1;
        chk("rst_prio ack", 32'(ack), 32'd0);
        rst = 1'b0; en = 1'b0;
        last_dout = '0;
        @(posedge clk); #1;
        chk("rst_prio quiet", {30'd0, stall, ack}, 32'd0);
        access(1'b0, 16'h0005, 16'h0000, 4'd0, 16'h5A5A, 1'b0, 1'b0, "rst_prio rd5");

        // Random traffic against the array model.
        for (int i = 0; i < 60; i++) begin
            bit          wr, oor;
            logic [15:0] a, d;
            logic [3:0]  n;
            wr  = 1'($urandom_range(0, 1));
            oor = ($urandom_range(0, 7) == 0);
            a   = {8'h00, 8'($urandom)};
            if (oor) a[15:8] = 8'($urandom_range(1, 255));
            if (!wr && !oor && !known[a[7:0]]) wr = 1'b1;
            d = 16'($urandom);
            n = 4'($urandom_range(0, 4));
            access(wr, a, d, n, oor ? 16'h0000 : ref_mem[a[7:0]], oor, 1'b0,
                   $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
